pc8001_video_timing: RTL and testbench
======================================

PC8001_VIDEO_TIMING -- requirements
Module: pc8001_video_timing

Interface
REQ-001 SHALL have parameter CE_DIV, default 2: clk_sys cycles per pixel in 80-column mode; minimum 2.
REQ-002 SHALL have parameter H_TOTAL, default 910: pixels per line.
REQ-003 SHALL have parameter H_ACTIVE, default 640: visible pixels per line.
REQ-004 SHALL have parameters H_SYNC_START / H_SYNC_LEN, defaults 720 / 68: first hsync pixel and hsync width.
REQ-005 SHALL have parameters V_TOTAL / V_ACTIVE, defaults 262 / 200: lines per frame and visible lines.
REQ-006 SHALL have parameters V_SYNC_START / V_SYNC_LEN, defaults 220 / 3: first vsync line and vsync height.
REQ-007 SHALL have parameters HS_POL / VS_POL, default 0: sync active level, 0 = active-low.
REQ-008 SHALL have parameter BLINK_BIT, default 4: frame_cnt bit driving blink.
REQ-009 SHALL have port clk_sys, input, 1: single clock; all logic is on its rising edge.
REQ-010 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-011 SHALL have port wide40, input, 1: 1 = 40-column mode, with the pixel period doubled to 2*CE_DIV.
REQ-012 SHALL have port ce_pix, output, 1: one-cycle pixel enable.
REQ-013 SHALL have ports hcount / vcount, output, clog2(H_TOTAL) / clog2(V_TOTAL): current pixel position.
REQ-014 SHALL have ports hblank, vblank, hsync, vsync, output, 1 each.
REQ-015 SHALL have port vbl_pulse, output, 1: one pulse per frame at vblank start.
REQ-016 SHALL have port frame_cnt, output, 8: count of frames.
REQ-017 SHALL have port blink, output, 1: equal to frame_cnt[BLINK_BIT].

Function
REQ-018 The divider SHALL count 0..last, where last = CE_DIV-1, or 2*CE_DIV-1 when the latched mode is 40-column.
- On the edge where the divider equals last: divider goes to 0, ce_pix goes to 1, and the position advances.
- On every other edge ce_pix SHALL be 0.
REQ-019 hcount SHALL advance on each ce_pix and wrap from H_TOTAL-1 to 0.
- vcount SHALL advance only on an hcount wrap, and wrap from V_TOTAL-1 to 0.
REQ-020 All outputs SHALL be registered and SHALL describe the new position in the same edge that raises ce_pix.
- Outputs SHALL be held constant between ce_pix pulses.
REQ-021 Blanking and sync SHALL be decoded as follows:
- hblank = (hcount >= H_ACTIVE); vblank = (vcount >= V_ACTIVE).
- hsync is active for hcount in [H_SYNC_START, H_SYNC_START+H_SYNC_LEN).
- vsync is active for vcount in [V_SYNC_START, V_SYNC_START+V_SYNC_LEN).
- The active sync level is set by HS_POL / VS_POL.
REQ-022 vbl_pulse SHALL be 1 for exactly one clk_sys cycle, coincident with ce_pix, at position (hcount 0, vcount V_ACTIVE).
REQ-023 wide40 SHALL be sampled into the mode register only at frame start, i.e. the ce_pix that moves to (0,0).
- A wide40 change mid-frame SHALL NOT alter the current frame's pixel period.
REQ-024 frame_cnt SHALL increment at each frame start and wrap from 255 to 0.
REQ-025 Parameter sanity SHALL be checked at elaboration: H_ACTIVE < H_TOTAL, V_ACTIVE < V_TOTAL, sync windows fit within totals, CE_DIV >= 2.
- Any violation SHALL be a fatal error.

Reset
REQ-026 While reset is high, the block SHALL immediately (asynchronously) enter its reset state:
- divider = 0, hcount = H_TOTAL-1, vcount = V_TOTAL-1.
- ce_pix = 0, vbl_pulse = 0, frame_cnt = 0.
- hblank = vblank = 1; hsync and vsync decoded from the reset counts.
- Mode register loaded from wide40.
REQ-027 After reset deassertion, the first ce_pix SHALL occur on the CE_DIV-th rising edge (2*CE_DIV in 40-column mode), presenting position (0,0).
- This first ce_pix counts as a frame start but SHALL NOT increment frame_cnt.
REQ-028 Reset mid-line or mid-frame SHALL abandon the current position with no partial pulse on any output.

Structure
REQ-029 Package pc8001_pkg SHALL hold:
- the default timing localparams (NTSC 15 kHz set above);
- the mode enum MODE_80COL / MODE_40COL.
REQ-030 The block SHALL use one sub-module, pc8001_wrap_cnt: a parametrised-width counter with enable and runtime terminal value, instantiated for the divider, hcount and vcount.

Verification
REQ-031 Release reset with wide40=0 -> first ce_pix on the 2nd edge at (0,0), then one ce_pix every 2 clocks.
REQ-032 One line at defaults -> hblank rises at hcount 640; hsync low for 720..787; hcount wraps 909->0 with vcount+1; line period 1820 clocks.
REQ-033 One frame at defaults -> vblank for lines 200..261; vsync low for lines 220..222; exactly one vbl_pulse; frame period 476840 clocks.
REQ-034 wide40 raised at vcount 100 -> ce_pix spacing stays 2 until the next (0,0), then becomes 4; next frame period 953680 clocks.
REQ-035 reset asserted at hcount 500 -> reset-state outputs in the same cycle; restart per REQ-027 after release.
REQ-036 Run 256 frames after reset -> frame_cnt wraps to 0; blink toggles every 16 frames.

Source files
------------

// File: rtl/pc8001_pkg.sv
// pc8001_pkg: default NTSC 15 kHz timing set, column-mode type and a window decode helper
// shared by the PC-8001 video timing block.
package pc8001_pkg;
    localparam int DEF_CE_DIV       = 2;
    localparam int DEF_H_TOTAL      = 910;
    localparam int DEF_H_ACTIVE     = 640;
    localparam int DEF_H_SYNC_START = 720;
    localparam int DEF_H_SYNC_LEN   = 68;
    localparam int DEF_V_TOTAL      = 262;
    localparam int DEF_V_ACTIVE     = 200;
    localparam int DEF_V_SYNC_START = 220;
    localparam int DEF_V_SYNC_LEN   = 3;
    localparam int DEF_BLINK_BIT    = 4;

    typedef enum logic {
        MODE_80COL = 1'b0,
        MODE_40COL = 1'b1
    } mode_t;

    function automatic logic in_window(int v, int s, int l);
        return (v >= s) && (v < s + l);
    endfunction
endpackage

// File: rtl/pc8001_wrap_cnt.sv
// pc8001_wrap_cnt: counter that steps on enable and wraps to zero after a runtime last value.
// The next value is exported so the parent can register decodes of the new position.
module pc8001_wrap_cnt #(
    parameter int           W       = 4,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    input  logic [W-1:0] i_last,
    output logic [W-1:0] o_q,
    output logic [W-1:0] o_next,
    output logic         o_at_last
);
    logic [W-1:0] r_q;

    assign o_q       = r_q;
    assign o_at_last = (r_q == i_last);
    assign o_next    = o_at_last ? '0 : r_q + W'(1);

    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst)
            r_q <= RST_VAL;
        else if (i_en)
            r_q <= o_next;
endmodule

// File: rtl/pc8001_video_timing.sv
// pc8001_video_timing: PC-8001 raster timing with 80/40-column pixel clock enable,
// registered blank/sync decode, vblank pulse and frame/blink counters.
module pc8001_video_timing
    import pc8001_pkg::*;
#(
    parameter int CE_DIV       = DEF_CE_DIV,
    parameter int H_TOTAL      = DEF_H_TOTAL,
    parameter int H_ACTIVE     = DEF_H_ACTIVE,
    parameter int H_SYNC_START = DEF_H_SYNC_START,
    parameter int H_SYNC_LEN   = DEF_H_SYNC_LEN,
    parameter int V_TOTAL      = DEF_V_TOTAL,
    parameter int V_ACTIVE     = DEF_V_ACTIVE,
    parameter int V_SYNC_START = DEF_V_SYNC_START,
    parameter int V_SYNC_LEN   = DEF_V_SYNC_LEN,
    parameter bit HS_POL       = 1'b0,
    parameter bit VS_POL       = 1'b0,
    parameter int BLINK_BIT    = DEF_BLINK_BIT
) (
    input  logic                       clk_sys,
    input  logic                       reset,
    input  logic                       wide40,
    output logic                       ce_pix,
    output logic [$clog2(H_TOTAL)-1:0] hcount,
    output logic [$clog2(V_TOTAL)-1:0] vcount,
    output logic                       hblank,
    output logic                       vblank,
    output logic                       hsync,
    output logic                       vsync,
    output logic                       vbl_pulse,
    output logic [7:0]                 frame_cnt,
    output logic                       blink
);
    localparam int             HW     = $clog2(H_TOTAL);
    localparam int             VW     = $clog2(V_TOTAL);
    localparam int             DW     = $clog2(2 * CE_DIV);
    localparam logic [HW-1:0]  H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0]  V_LAST = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0]  H_ACT  = HW'(H_ACTIVE);
    localparam logic [VW-1:0]  V_ACT  = VW'(V_ACTIVE);
    localparam logic           HS_RST = in_window(H_TOTAL - 1, H_SYNC_START, H_SYNC_LEN) ~^ HS_POL;
    localparam logic           VS_RST = in_window(V_TOTAL - 1, V_SYNC_START, V_SYNC_LEN) ~^ VS_POL;

    if (CE_DIV < 2 || H_ACTIVE >= H_TOTAL || V_ACTIVE >= V_TOTAL ||
        H_SYNC_START + H_SYNC_LEN > H_TOTAL || V_SYNC_START + V_SYNC_LEN > V_TOTAL ||
        BLINK_BIT < 0 || BLINK_BIT > 7) begin : g_bad_params
        $fatal(1, "pc8001_video_timing: invalid timing parameters");
    end

    mode_t         r_mode;
    logic          r_ce;
    logic          r_vbl;
    logic          r_hblank;
    logic          r_vblank;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_first;
    logic [7:0]    r_frame;
    logic [DW-1:0] w_div_last;
    logic [DW-1:0] w_div_q;
    logic [DW-1:0] w_div_next;
    logic          w_tick;
    logic [HW-1:0] w_hq;
    logic [HW-1:0] w_hnext;
    logic          w_hlast;
    logic [VW-1:0] w_vq;
    logic [VW-1:0] w_vnext;
    logic          w_vlast;
    logic [VW-1:0] w_vnew;
    logic          w_frame;

    assign w_div_last = (r_mode == MODE_40COL) ? DW'(2 * CE_DIV - 1) : DW'(CE_DIV - 1);
    assign w_vnew     = w_hlast ? w_vnext : w_vq;
    assign w_frame    = w_tick && w_hlast && w_vlast;

    pc8001_wrap_cnt #(.W(DW), .RST_VAL('0)) u_div (
        .i_clk(clk_sys), .i_rst(reset), .i_en(1'b1), .i_last(w_div_last),
        .o_q(w_div_q), .o_next(w_div_next), .o_at_last(w_tick)
    );

    pc8001_wrap_cnt #(.W(HW), .RST_VAL(H_LAST)) u_h (
        .i_clk(clk_sys), .i_rst(reset), .i_en(w_tick), .i_last(H_LAST),
        .o_q(w_hq), .o_next(w_hnext), .o_at_last(w_hlast)
    );

    pc8001_wrap_cnt #(.W(VW), .RST_VAL(V_LAST)) u_v (
        .i_clk(clk_sys), .i_rst(reset), .i_en(w_tick && w_hlast), .i_last(V_LAST),
        .o_q(w_vq), .o_next(w_vnext), .o_at_last(w_vlast)
    );

    // Decodes are computed from the next position so they change on the same edge as ce_pix.
    always_ff @(posedge clk_sys or posedge reset)
        if (reset) begin
            r_ce     <= 1'b0;
            r_vbl    <= 1'b0;
            r_hblank <= 1'b1;
            r_vblank <= 1'b1;
            r_hsync  <= HS_RST;
            r_vsync  <= VS_RST;
            r_frame  <= '0;
            r_first  <= 1'b1;
            r_mode   <= mode_t'(wide40);
        end else begin
            r_ce  <= w_tick;
            r_vbl <= w_tick && w_hlast && (w_vnext == V_ACT);
            if (w_tick) begin
                r_hblank <= w_hnext >= H_ACT;
                r_vblank <= w_vnew >= V_ACT;
                r_hsync  <= in_window(int'(w_hnext), H_SYNC_START, H_SYNC_LEN) ~^ HS_POL;
                r_vsync  <= in_window(int'(w_vnew), V_SYNC_START, V_SYNC_LEN) ~^ VS_POL;
            end
            if (w_frame) begin
                r_mode  <= mode_t'(wide40);
                r_first <= 1'b0;
                if (!r_first)
                    r_frame <= r_frame + 8'd1;
            end
        end

    assign ce_pix    = r_ce;
    assign hcount    = w_hq;
    assign vcount    = w_vq;
    assign hblank    = r_hblank;
    assign vblank    = r_vblank;
    assign hsync     = r_hsync;
    assign vsync     = r_vsync;
    assign vbl_pulse = r_vbl;
    assign frame_cnt = r_frame;
    assign blink     = r_frame[BLINK_BIT];
endmodule

// File: tb/tb_pc8001_video_timing.sv
// tb_pc8001_video_timing: randomized bench for pc8001_video_timing on a reduced raster,
// compared every cycle against a pixel-period/position reference model.
module tb_pc8001_video_timing;
    localparam int CE = 2, HT = 12, HA = 8, HSS = 9, HSL = 2;
    localparam int VT = 6, VA = 4, VSS = 4, VSL = 1, BB = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wide40 = 1'b0;
    logic       ce_pix, hblank, vblank, hsync, vsync, vbl_pulse, blink;
    logic [3:0] hcount;
    logic [2:0] vcount;
    logic [7:0] frame_cnt;
    logic [21:0] dut_vec;
    int n_cmp = 0;
    int n_err = 0;

    // model state: clocks since last pixel, position, mode, frame count
    int m_cnt, m_h, m_v, m_frame;
    bit m_ce, m_w40, m_first;

    pc8001_video_timing #(
        .CE_DIV(CE), .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_LEN(HSL),
        .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_LEN(VSL),
        .HS_POL(1'b0), .VS_POL(1'b1), .BLINK_BIT(BB)
    ) dut (
        .clk_sys(clk), .reset(reset), .wide40(wide40), .ce_pix(ce_pix),
        .hcount(hcount), .vcount(vcount), .hblank(hblank), .vblank(vblank),
        .hsync(hsync), .vsync(vsync), .vbl_pulse(vbl_pulse),
        .frame_cnt(frame_cnt), .blink(blink)
    );

    always #5 clk = ~clk;

    assign dut_vec = {ce_pix, hcount, vcount, hblank, vblank, hsync, vsync, vbl_pulse, frame_cnt, blink};

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cnt = 0; m_ce = 0; m_h = HT - 1; m_v = VT - 1;
            m_frame = 0; m_first = 1; m_w40 = wide40;
        end else begin
            m_cnt++;
            m_ce = 0;
            if (m_cnt == (m_w40 ? 2 * CE : CE)) begin
                m_cnt = 0;
                m_ce = 1;
                m_h = (m_h + 1) % HT;
                if (m_h == 0) m_v = (m_v + 1) % VT;
                if (m_h == 0 && m_v == 0) begin
                    m_w40 = wide40;
                    if (m_first) m_first = 0;
                    else m_frame = (m_frame + 1) % 256;
                end
            end
        end
    end

    function automatic logic [21:0] exp_vec();
        return {m_ce, 4'(m_h), 3'(m_v), m_h >= HA, m_v >= VA,
                !(m_h >= HSS && m_h < HSS + HSL), (m_v >= VSS && m_v < VSS + VSL),
                m_ce && m_h == 0 && m_v == VA, 8'(m_frame), ((m_frame >> BB) & 1) == 1};
    endfunction

    task automatic test_reset;
        int first = -1;
        wide40 = 0;
        reset = 1;
        @(negedge clk);
        n_cmp++; if (dut_vec !== exp_vec()) begin n_err++; $display("FAIL reset_vec: dut=%h exp=%h", dut_vec, exp_vec()); end
        n_cmp++;
        if ({ce_pix, hcount, vcount, hblank, vblank, hsync, vsync, vbl_pulse, frame_cnt} !== {1'b0, 4'd11, 3'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0}) begin
            n_err++; $display("FAIL reset_const: dut=%h", dut_vec);
        end
        reset = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            n_cmp++; if (dut_vec !== exp_vec()) begin n_err++; $display("FAIL release: dut=%h exp=%h", dut_vec, exp_vec()); end
            if (ce_pix && first < 0) begin
                first = i;
                n_cmp++; if ({hcount, vcount} !== 7'd0) begin n_err++; $display("FAIL first_pos: dut=%h exp=0", {hcount, vcount}); end
            end
        end
        n_cmp++; if (first != 2) begin n_err++; $display("FAIL first_ce_edge: got %0d want 2", first); end
    endtask

    task automatic test_line;
        int t0 = -1, t1 = -1;
        for (int i = 0; i < 100 && t1 < 0; i++) begin
            @(negedge clk);
            n_cmp++; if (dut_vec !== exp_vec()) begin n_err++; $display("FAIL line: dut=%h exp=%h", dut_vec, exp_vec()); end
            if (ce_pix && hcount == 4'd0) begin
                if (t0 < 0) t0 = i; else t1 = i;
            end
        end
        n_cmp++; if (t1 < 0 || t1 - t0 != HT * CE) begin n_err++; $display("FAIL line_period: got %0d want %0d", t1 - t0, HT * CE); end
    endtask

    task automatic test_frame;
        int t0 = -1, t1 = -1, vbls = 0;
        for (int i = 0; i < 400 && t1 < 0; i++) begin
            @(negedge clk);
            n_cmp++; if (dut_vec !== exp_vec()) begin n_err++; $display("FAIL frame: dut=%h exp=%h", dut_vec, exp_vec()); end
            if (t0 >= 0 && vbl_pulse) vbls++;
            if (ce_pix && hcount == 4'd0 && vcount == 3'd0) begin
                if (t0 < 0) t0 = i; else t1 = i;
            end
        end
        n_cmp++; if (t1 < 0 || t1 - t0 != HT * VT * CE) begin n_err++; $display("FAIL frame_period: got %0d want %0d", t1 - t0, HT * VT * CE); end
        n_cmp++; if (vbls != 1) begin n_err++; $display("FAIL vbl_count: got %0d want 1", vbls); end
    endtask

    task automatic test_wide40;
        bit seen = 0;
        int t = 0, last = -1, bad2 = 0, bad4 = 0, fs0 = -1, fs1 = -1;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            n_cmp++; if (dut_vec !== exp_vec()) begin n_err++; $display("FAIL w40_pre: dut=%h exp=%h", dut_vec, exp_vec()); end
            if (ce_pix && vcount == 3'd2) seen = 1;
        end
        n_cmp++; if (!seen) begin n_err++; $display("FAIL w40_reach: vcount 2 not seen"); end
        wide40 = 1;
        for (int i = 0; i < 1200 && fs1 < 0; i++) begin
            @(negedge clk);
            t++;
            if (fs0 >= 0 && t == fs0 + 50) wide40 = 0;
            n_cmp++; if (dut_vec !== exp_vec()) begin n_err++; $display("FAIL w40: dut=%h exp=%h", dut_vec, exp_vec()); end
            if (ce_pix) begin
                if (last >= 0 && fs0 < 0 && t - last != CE) bad2++;
                if (last >= 0 && fs0 >= 0 && t - last != 2 * CE) bad4++;
                last = t;
                if (hcount == 4'd0 && vcount == 3'd0) begin
                    if (fs0 < 0) fs0 = t; else fs1 = t;
                end
            end
        end
        n_cmp++; if (bad2 != 0) begin n_err++; $display("FAIL w40_old_period: %0d gaps not %0d", bad2, CE); end
        n_cmp++; if (bad4 != 0) begin n_err++; $display("FAIL w40_new_period: %0d gaps not %0d", bad4, 2 * CE); end
        n_cmp++; if (fs1 < 0 || fs1 - fs0 != 2 * HT * VT * CE) begin n_err++; $display("FAIL w40_frame: got %0d want %0d", fs1 - fs0, 2 * HT * VT * CE); end
    endtask

    task automatic test_reset_mid;
        bit seen = 0;
        bit w = 1'($urandom_range(0, 1));
        int first = -1;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            n_cmp++; if (dut_vec !== exp_vec()) begin n_err++; $display("FAIL rmid_pre: dut=%h exp=%h", dut_vec, exp_vec()); end
            if (ce_pix && hcount == 4'd5) seen = 1;
        end
        n_cmp++; if (!seen) begin n_err++; $display("FAIL rmid_reach: hcount 5 not seen"); end
        @(negedge clk);
        wide40 = w;
        #1 reset = 1;
        #1;
        n_cmp++; if (dut_vec !== exp_vec()) begin n_err++; $display("FAIL rmid_vec: dut=%h exp=%h", dut_vec, exp_vec()); end
        n_cmp++;
        if ({ce_pix, hcount, vcount, hblank, vblank, vbl_pulse, frame_cnt} !== {1'b0, 4'd11, 3'd5, 1'b1, 1'b1, 1'b0, 8'd0}) begin
            n_err++; $display("FAIL rmid_const: dut=%h", dut_vec);
        end
        @(negedge clk);
        reset = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            n_cmp++; if (dut_vec !== exp_vec()) begin n_err++; $display("FAIL rmid_post: dut=%h exp=%h", dut_vec, exp_vec()); end
            if (ce_pix && first < 0) first = i;
        end
        n_cmp++; if (first != (w ? 2 * CE : CE)) begin n_err++; $display("FAIL rmid_first: got %0d want %0d", first, w ? 2 * CE : CE); end
        wide40 = 0;
    endtask

    task automatic test_frame_wrap;
        int toggles = 0, maxf = 0;
        logic prev;
        wide40 = 0;
        reset = 1;
        @(negedge clk);
        reset = 0;
        prev = blink;
        for (int i = 0; i < 256 * HT * VT * CE + 10; i++) begin
            @(negedge clk);
            n_cmp++; if (dut_vec !== exp_vec()) begin n_err++; $display("FAIL wrap: dut=%h exp=%h", dut_vec, exp_vec()); end
            if (blink !== prev) toggles++;
            prev = blink;
            if (int'(frame_cnt) > maxf) maxf = int'(frame_cnt);
        end
        n_cmp++; if (frame_cnt !== 8'd0) begin n_err++; $display("FAIL wrap_zero: got %0d want 0", frame_cnt); end
        n_cmp++; if (maxf != 255) begin n_err++; $display("FAIL wrap_max: got %0d want 255", maxf); end
        n_cmp++; if (toggles != 16) begin n_err++; $display("FAIL blink_toggles: got %0d want 16", toggles); end
    endtask

    task automatic test_random;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            n_cmp++; if (dut_vec !== exp_vec()) begin n_err++; $display("FAIL random: dut=%h exp=%h", dut_vec, exp_vec()); end
            reset = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 199) == 0) wide40 = ~wide40;
        end
        reset = 0;
    endtask

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_wide40();
        test_reset_mid();
        test_frame_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
